// File: rtl/pifo_tree_op_scheduler.sv
// Front-end arbiter for the SRAM PIFO tree: round-robin push requesters, one pop
// requester, minimum issue spacing, occupancy tracking and pop-result return.
module pifo_tree_op_scheduler #(
    parameter int PTW     = 16,
    parameter int MTW     = 32,
    parameter int NREQ    = 4,
    parameter int GAP     = 2,
    parameter int POP_LAT = 2,
    parameter int CAP     = 87380,
    parameter int CNTW    = 17
) (
    input  logic                          i_clk,
    input  logic                          i_arst,
    input  logic [NREQ-1:0]               i_push_req,
    input  logic [NREQ*(MTW+PTW)-1:0]     i_push_data,
    output logic [NREQ-1:0]               o_push_ack,
    input  logic                          i_pop_req,
    output logic                          o_pop_ack,
    output logic                          o_pop_valid,
    output logic [MTW+PTW-1:0]            o_pop_result,
    output logic                          o_push,
    output logic [MTW+PTW-1:0]            o_push_data,
    output logic                          o_pop,
    input  logic [MTW+PTW-1:0]            i_pop_data,
    output logic [CNTW-1:0]               o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int DW  = MTW + PTW;
    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNTW-1:0]  CAP_C  = CNTW'(CAP);
    localparam logic [RRW:0]     NREQ_C = (RRW+1)'(NREQ);

    logic [CNTW-1:0]    r_count;
    logic [RRW-1:0]     r_rr;
    logic               r_last_pop;
    logic [GW-1:0]      r_gap;
    logic [POP_LAT-1:0] r_pop_pipe;
    logic [DW-1:0]      r_pop_hold;

    logic [2*NREQ-1:0]  w_req_dbl;
    logic [NREQ-1:0]    w_req_rot;
    logic [RRW-1:0]     w_off;
    logic [RRW:0]       w_sum;
    logic [RRW-1:0]     w_win;
    logic [RRW:0]       w_win_p1;
    logic               w_slot;
    logic               w_push_elig;
    logic               w_pop_elig;
    logic               w_push_issue;
    logic               w_pop_issue;
    logic [DW-1:0]      w_sel_data;

    // Nothing issues while reset is held, even though registers already read as idle.
    assign w_slot      = (r_gap == '0) && !i_arst;
    assign w_push_elig = (|i_push_req) && (r_count < CAP_C);
    assign w_pop_elig  = i_pop_req && (r_count != '0);

    // When both are eligible, the kind opposite to the last issued op wins.
    assign w_push_issue = w_slot && w_push_elig && (!w_pop_elig || r_last_pop);
    assign w_pop_issue  = w_slot && w_pop_elig && !w_push_issue;

    // Rotate requests so bit 0 is the requester at the rr pointer.
    assign w_req_dbl = {i_push_req, i_push_req};

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign w_req_rot[gi] = w_req_dbl[r_rr + gi];
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = RRW'(i);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr} + {1'b0, w_off};
    assign w_win    = (w_sum >= NREQ_C) ? RRW'(w_sum - NREQ_C) : w_sum[RRW-1:0];
    assign w_win_p1 = {1'b0, w_win} + (RRW+1)'(1);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == RRW'(i)) begin
                w_sel_data = i_push_data[i*DW +: DW];
            end
        end
    end

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ack
            assign o_push_ack[gi] = w_push_issue && (w_win == RRW'(gi));
        end
    endgenerate

    assign o_push      = w_push_issue;
    assign o_push_data = w_push_issue ? w_sel_data : '0;
    assign o_pop       = w_pop_issue;
    assign o_pop_ack   = w_pop_issue;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_count    <= '0;
            r_rr       <= '0;
            r_last_pop <= 1'b1;
            r_gap      <= '0;
        end else begin
            if (w_push_issue || w_pop_issue) begin
                r_gap      <= GW'(GAP - 1);
                r_last_pop <= w_pop_issue;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GW'(1);
            end
            if (w_push_issue) begin
                r_count <= r_count + CNTW'(1);
                r_rr    <= (w_win_p1 == NREQ_C) ? '0 : w_win_p1[RRW-1:0];
            end else if (w_pop_issue) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

    // Each bit marks an in-flight pop; the tail lines up with the tree's data.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_pop_pipe <= '0;
            r_pop_hold <= '0;
        end else begin
            r_pop_pipe <= (r_pop_pipe << 1) | POP_LAT'(w_pop_issue);
            if (r_pop_pipe[POP_LAT-1]) begin
                r_pop_hold <= i_pop_data;
            end
        end
    end

    assign o_pop_valid  = r_pop_pipe[POP_LAT-1];
    assign o_pop_result = o_pop_valid ? i_pop_data : r_pop_hold;

    assign o_count = r_count;
    assign o_full  = (r_count == CAP_C);
    assign o_empty = (r_count == '0);

endmodule
